// File: rtl/muldiv_sequencer_pkg.sv
// mips_pkg: shared definitions for the multiply/divide sequencer.
//   MD_MULT/MD_MULTU/MD_DIV/MD_DIVU : op encodings on the 2-bit op input
//   md_state_e                       : sequencer FSM states
//   MD_ITER                          : default operand width / iteration count
package mips_pkg;

    localparam int unsigned MD_ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_RUN,
        MD_FIX,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle of the multiply/divide sequencer.
//   master : pipeline/control (drives start, op, a, b, hi_we, lo_we, wdata)
//   slave  : sequencer (drives busy, done, hi, lo)
interface muldiv_sequencer_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_ITER
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide sequencer owning the HI/LO registers.
// Ports:
//   clock   : system clock, rising edge
//   reset   : synchronous, active-high
//   bus     : muldiv_sequencer_if.slave (start/op/a/b, MTHI/MTLO writes,
//             busy/done status, hi/lo architectural registers)
// One (WIDTH+1)-bit adder/subtractor and one 2*WIDTH negate unit are shared
// across PREP (operand magnitudes), RUN (iterations) and FIX (sign fix-up).
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_ITER
) (
    input  logic              clock,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e      state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [2*W-1:0] acc_q, acc_d;        // product, or remainder:quotient
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic           is_signed, is_div;
    logic [W:0]     add_x, add_y, add_s;
    logic           add_sub;
    logic [2*W-1:0] neg_in, neg_out;
    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] prod;

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];

    assign add_s   = add_x + (add_sub ? ~add_y : add_y) + {{W{1'b0}}, add_sub};
    assign neg_out = -neg_in;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        add_x     = '0;
        add_y     = '0;
        add_sub   = 1'b0;
        neg_in    = '0;
        mag_a     = '0;
        mag_b     = '0;
        prod      = '0;

        case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = MD_PREP;
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end

            MD_PREP: begin
                // |a| via the negate unit, |b| via the adder (0 - b).
                neg_in    = {{W{1'b0}}, a_q};
                add_y     = {1'b0, b_q};
                add_sub   = 1'b1;
                mag_a     = (is_signed && a_q[W-1]) ? neg_out[W-1:0] : a_q;
                mag_b     = (is_signed && b_q[W-1]) ? add_s[W-1:0]   : b_q;
                neg_res_d = is_signed & (a_q[W-1] ^ b_q[W-1]);
                neg_rem_d = is_signed & is_div & a_q[W-1];
                cnt_d     = '0;
                if (is_div) begin
                    acc_d  = {{W{1'b0}}, mag_a};
                    opnd_d = mag_b;
                end else begin
                    acc_d  = {{W{1'b0}}, mag_b};
                    opnd_d = mag_a;
                end
                if (is_div && b_q == '0) begin
                    hi_d    = a_q;
                    lo_d    = '1;
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_RUN;
                end
            end

            MD_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (!is_div) begin
                    add_x = {1'b0, acc_q[2*W-1:W]};
                    add_y = acc_q[0] ? {1'b0, opnd_q} : '0;
                    // carry-out becomes the top bit after the right shift
                    acc_d = {add_s, acc_q[W-1:1]};
                end else begin
                    // shifted remainder is acc_q[2W-1:W-1]; bit W of the
                    // difference is the borrow of the trial subtract
                    add_x   = acc_q[2*W-1:W-1];
                    add_y   = {1'b0, opnd_q};
                    add_sub = 1'b1;
                    if (!add_s[W]) acc_d = {add_s[W-1:0], acc_q[W-2:0], 1'b1};
                    else           acc_d = {acc_q[2*W-2:0], 1'b0};
                end
                if (cnt_q == CW'(W-1)) state_d = MD_FIX;
            end

            MD_FIX: begin
                if (!is_div) begin
                    neg_in = acc_q;
                    prod   = neg_res_q ? neg_out : acc_q;
                    hi_d   = prod[2*W-1:W];
                    lo_d   = prod[W-1:0];
                end else begin
                    // quotient through the negate unit, remainder through the adder
                    neg_in  = {{W{1'b0}}, acc_q[W-1:0]};
                    add_y   = {1'b0, acc_q[2*W-1:W]};
                    add_sub = 1'b1;
                    lo_d    = neg_res_q ? neg_out[W-1:0] : acc_q[W-1:0];
                    hi_d    = neg_rem_q ? add_s[W-1:0]   : acc_q[2*W-1:W];
                end
                state_d = MD_DONE;
            end

            MD_DONE: state_d = MD_IDLE;

            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q != MD_IDLE);
    assign bus.done = (state_q == MD_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import mips_pkg::*;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // advance one rising edge and step just past it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called right after the accepting edge E0; observes until busy drops.
    task automatic wait_idle(output int busy_cycles, output int done_at, output int done_count);
        int k;
        busy_cycles = 0;
        done_at     = -1;
        done_count  = 0;
        for (k = 0; k < 200; k++) begin
            if (bus.done) begin
                done_count++;
                if (done_at < 0) done_at = k;
            end
            if (!bus.busy) break;
            busy_cycles++;
            tick();
        end
        vectors++;
        if (k >= 200) begin
            miscompares++;
            $display("FAIL wait_idle_timeout busy still high after %0d cycles, required idle", k);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_at, output int done_count);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        wait_idle(busy_cycles, done_at, done_count);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 00000000", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 00000000", bus.lo); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_multu_max();
        int bc, da, dc;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, da, dc);
        vectors++; if (bus.hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_max_hi got %h want fffffffe", bus.hi); end
        vectors++; if (bus.lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_max_lo got %h want 00000001", bus.lo); end
        vectors++; if (bc !== 35) begin miscompares++; $display("FAIL multu_busy_cycles got %0d want 35", bc); end
        vectors++; if (da !== 34) begin miscompares++; $display("FAIL multu_done_edge got %0d want 34", da); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL multu_done_count got %0d want 1", dc); end
    endtask

    task automatic test_signed();
        int bc, da, dc;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, bc, da, dc);
        vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_neg3x5_hi got %h want ffffffff", bus.hi); end
        vectors++; if (bus.lo !== 32'hFFFF_FFF1) begin miscompares++; $display("FAIL mult_neg3x5_lo got %h want fffffff1", bus.lo); end
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, bc, da, dc);
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL mult_neg2xneg3_hi got %h want 00000000", bus.hi); end
        vectors++; if (bus.lo !== 32'd6) begin miscompares++; $display("FAIL mult_neg2xneg3_lo got %h want 00000006", bus.lo); end
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, bc, da, dc);
        vectors++; if (bus.lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg7_2_lo got %h want fffffffd", bus.lo); end
        vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg7_2_hi got %h want ffffffff", bus.hi); end
        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, bc, da, dc);
        vectors++; if (bus.lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_7_neg2_lo got %h want fffffffd", bus.lo); end
        vectors++; if (bus.hi !== 32'd1) begin miscompares++; $display("FAIL div_7_neg2_hi got %h want 00000001", bus.hi); end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, da, dc);
        vectors++; if (bus.lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_min_neg1_lo got %h want 80000000", bus.lo); end
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL div_min_neg1_hi got %h want 00000000", bus.hi); end
        run_op(MD_DIVU, 32'd100, 32'd7, bc, da, dc);
        vectors++; if (bus.lo !== 32'd14) begin miscompares++; $display("FAIL divu_100_7_lo got %h want 0000000e", bus.lo); end
        vectors++; if (bus.hi !== 32'd2) begin miscompares++; $display("FAIL divu_100_7_hi got %h want 00000002", bus.hi); end
    endtask

    task automatic test_div_zero();
        int bc, da, dc;
        run_op(MD_DIVU, 32'h0000_1234, 32'h0, bc, da, dc);
        vectors++; if (bus.hi !== 32'h0000_1234) begin miscompares++; $display("FAIL divu0_hi got %h want 00001234", bus.hi); end
        vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu0_lo got %h want ffffffff", bus.lo); end
        vectors++; if (da !== 1) begin miscompares++; $display("FAIL divu0_done_edge got %0d want 1", da); end
        vectors++; if (bc !== 2) begin miscompares++; $display("FAIL divu0_busy_cycles got %0d want 2", bc); end
        run_op(MD_DIV, 32'hFFFF_FFFB, 32'h0, bc, da, dc);
        vectors++; if (bus.hi !== 32'hFFFF_FFFB) begin miscompares++; $display("FAIL div0_hi got %h want fffffffb", bus.hi); end
        vectors++; if (bus.lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_lo got %h want ffffffff", bus.lo); end
    endtask

    task automatic test_start_ignored();
        int bc, da, dc, extra;
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd2; bus.b = 32'd3;
        tick();                                   // E0
        bus.start = 1'b0;
        repeat (9) tick();                        // E1..E9
        bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd3;
        tick();                                   // E10
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        wait_idle(bc, da, dc);
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL ignored_start_hi got %h want 00000000", bus.hi); end
        vectors++; if (bus.lo !== 32'd6) begin miscompares++; $display("FAIL ignored_start_lo got %h want 00000006", bus.lo); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL ignored_start_done_count got %0d want 1", dc); end
        extra = 0;
        repeat (5) begin tick(); if (bus.busy) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL ignored_start_requeued busy_cycles got %0d want 0", extra); end
    endtask

    task automatic test_mthi_mtlo();
        int bc, da, dc;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_AAAA;
        tick();
        bus.hi_we = 1'b0;
        vectors++; if (bus.hi !== 32'h0000_AAAA) begin miscompares++; $display("FAIL mthi_hi got %h want 0000aaaa", bus.hi); end
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_5555;
        tick();
        bus.lo_we = 1'b0;
        vectors++; if (bus.lo !== 32'h0000_5555) begin miscompares++; $display("FAIL mtlo_lo got %h want 00005555", bus.lo); end
        vectors++; if (bus.hi !== 32'h0000_AAAA) begin miscompares++; $display("FAIL mtlo_hi_kept got %h want 0000aaaa", bus.hi); end
        // MTLO while RUN is in progress
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd2; bus.b = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.lo_we = 1'b0;
        vectors++; if (bus.lo !== 32'h0000_5555) begin miscompares++; $display("FAIL mtlo_in_run_lo got %h want 00005555", bus.lo); end
        vectors++; if (bus.hi !== 32'h0000_AAAA) begin miscompares++; $display("FAIL hi_stable_in_run got %h want 0000aaaa", bus.hi); end
        wait_idle(bc, da, dc);
        vectors++; if (bus.lo !== 32'd6) begin miscompares++; $display("FAIL mtlo_in_run_result got %h want 00000006", bus.lo); end
        // MTHI in the same cycle as start: the write is dropped
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd4; bus.b = 32'd5;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_BEEF;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0;
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL mthi_with_start_hi got %h want 00000000", bus.hi); end
        wait_idle(bc, da, dc);
        vectors++; if (bus.lo !== 32'd20) begin miscompares++; $display("FAIL mthi_with_start_lo got %h want 00000014", bus.lo); end
    endtask

    task automatic test_reset_mid();
        int bc, da, dc, seen;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_1111;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7;
        tick();                                   // E0
        bus.start = 1'b0;
        repeat (14) tick();                       // E1..E14
        reset = 1'b1;
        tick();                                   // E15
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midreset_done got %b want 0", bus.done); end
        vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL midreset_hi got %h want 00000000", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL midreset_lo got %h want 00000000", bus.lo); end
        reset = 1'b0;
        seen = 0;
        repeat (40) begin tick(); if (bus.done || bus.busy) seen++; end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midreset_resumed active_cycles got %0d want 0", seen); end
        run_op(MD_MULTU, 32'd2, 32'd3, bc, da, dc);
        vectors++; if (bus.lo !== 32'd6) begin miscompares++; $display("FAIL post_reset_lo got %h want 00000006", bus.lo); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL post_reset_done_count got %0d want 1", dc); end
    endtask

    task automatic test_back_to_back();
        int bc, da, dc;
        run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, bc, da, dc);
        vectors++; if (bus.hi !== 32'd1) begin miscompares++; $display("FAIL b2b_mul_hi got %h want 00000001", bus.hi); end
        vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL b2b_mul_lo got %h want 00000000", bus.lo); end
        // started in the very first IDLE cycle
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h10, bc, da, dc);
        vectors++; if (bus.lo !== 32'h0FFF_FFFF) begin miscompares++; $display("FAIL b2b_div_lo got %h want 0fffffff", bus.lo); end
        vectors++; if (bus.hi !== 32'hF) begin miscompares++; $display("FAIL b2b_div_hi got %h want 0000000f", bus.hi); end
        vectors++; if (da !== 34) begin miscompares++; $display("FAIL b2b_div_done_edge got %0d want 34", da); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = '0;

        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_start_ignored();
        test_mthi_mtlo();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
